adpcm_stream_ctrl: RTL and testbench
====================================

ADPCM_STREAM_CTRL -- requirements
Module: adpcm_stream_ctrl

Interface
REQ-001 Parameters SHALL be:
- DECIM, default 64: clk cycles per decimation strobe (≥2).
- WARMUP, default 4: strobes discarded after start while the CIC settles.
- BLOCK_LEN, default 256: nibbles per block (even, ≥2).
- FIFO_DEPTH, default 4: output byte FIFO entries (power of 2).
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle block start request.
- stop  in  1  one-cycle abort request.
- enc_valid  in  1  compressor output strobe.
- enc_pcm  in  4  compressor ADPCM nibble.
- slow_en  out  1  decimation strobe to the compressor.
- blk_en  out  1  compressor block enable.
- out_data  out  8  packed byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accept.
- busy  out  1  state is not IDLE.
- overflow  out  1  sticky byte-drop flag.

Function
REQ-003 The FSM SHALL have states IDLE, WARMUP, RUN, FLUSH.
REQ-004 IDLE→WARMUP on start; start SHALL be ignored in every other state.
REQ-005 The decimation counter SHALL run only outside IDLE, pulse slow_en for one cycle every DECIM cycles (first pulse DECIM cycles after leaving IDLE), and reset to 0 on entering IDLE.
REQ-006 blk_en SHALL be 1 in WARMUP and RUN, and 0 in IDLE and FLUSH.
REQ-007 WARMUP→RUN on the cycle after the WARMUP-th slow_en pulse; enc_valid SHALL be ignored in WARMUP.
REQ-008 In RUN, each enc_valid SHALL capture enc_pcm: even-index nibble → low half of the pack register, odd-index nibble → high half, and the completed byte SHALL be pushed the same cycle.
REQ-009 The nibble counter SHALL be sized for BLOCK_LEN. When the BLOCK_LEN-th nibble is captured, the state SHALL go RUN→FLUSH.
REQ-010 stop in WARMUP or RUN SHALL go to FLUSH. If an odd nibble is pending, it SHALL be pushed with a zero high half; otherwise the partial count is discarded.
REQ-011 FLUSH→IDLE when the FIFO is empty and no push is in progress.
REQ-012 The FIFO SHALL be first-word-fall-through: out_valid = not empty; out_data = head entry.
- A pop occurs when out_valid and out_ready are both 1.
- Latency: a byte pushed at cycle N into an empty FIFO SHALL appear at cycle N+1.
REQ-013 Push while full with a simultaneous pop SHALL succeed. Push while full without a pop SHALL drop the byte and set overflow.
REQ-014 overflow SHALL clear only on rst or on an accepted start.
REQ-015 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 stop and start in the same cycle from IDLE: start SHALL win. stop in IDLE or FLUSH SHALL be ignored.

Reset
REQ-017 rst SHALL asynchronously force: state IDLE, all counters 0, pack register 0, FIFO empty, and outputs slow_en=0, blk_en=0, out_valid=0, out_data=0, busy=0, overflow=0.
REQ-018 rst asserted mid-RUN SHALL discard all pending nibbles and FIFO contents, with no partial byte emitted after release.

Structure
REQ-019 Package adpcm_ctrl_pkg SHALL hold:
- the state enum;
- default values for DECIM, WARMUP, BLOCK_LEN and FIFO_DEPTH;
- the nibble and byte widths.
REQ-020 The FIFO SHALL be a separate sub-module, byte_fifo (parameter DEPTH; ports push, pop, din, dout, full, empty), clocked by clk and reset by rst.

Verification
REQ-021 Warmup and first byte: DECIM=4, WARMUP=2, start → slow_en at cycles 4, 8, 12; blk_en high from cycle 1; enc_valid with 0x3 then 0xA in RUN → out_data=0xA3, out_valid=1 one cycle after the second nibble.
REQ-022 Full block: BLOCK_LEN=8, nibbles 1..8, out_ready=1 → bytes 0x21, 0x43, 0x65, 0x87, then busy falls once the FIFO is empty.
REQ-023 Odd stop: stop after 3 nibbles (5, 6, 7) → bytes 0x65, 0x07, then IDLE.
REQ-024 Backpressure/overflow: FIFO_DEPTH=4, out_ready=0, 12 nibbles → 4 bytes retained, overflow=1, out_data stable; out_ready=1 → 4 bytes drained in order; next start clears overflow.
REQ-025 Full push with pop: FIFO full, push and pop in the same cycle → no overflow, occupancy stays 4.
REQ-026 Async reset: rst pulsed mid-RUN with 1 nibble pending → all outputs 0 immediately; after release, no byte emitted until a new start.

Source files
------------

// File: rtl/adpcm_ctrl_pkg.sv
// Shared types and defaults for the ADPCM stream controller.
// State literals carry an S_ prefix so they never collide with the WARMUP parameter.
package adpcm_ctrl_pkg;
    localparam int DECIM_DEF      = 64;
    localparam int WARMUP_DEF     = 4;
    localparam int BLOCK_LEN_DEF  = 256;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;
endpackage

// File: rtl/adpcm_stream_ctrl_if.sv
// Packed-byte output stream of the ADPCM controller.
interface adpcm_stream_ctrl_if;
    import adpcm_ctrl_pkg::*;

    // A byte transfers on every clock edge where out_valid and out_ready are both 1;
    // while out_valid=1 and out_ready=0 the source holds out_data unchanged.
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO succeeds only alongside a pop.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/adpcm_stream_ctrl.sv
// Sequences compressor warm-up, packs ADPCM nibble pairs into bytes and queues them
// for a valid/ready consumer; the FSM state is exported for observation.
module adpcm_stream_ctrl
    import adpcm_ctrl_pkg::*;
#(
    parameter int DECIM      = DECIM_DEF,
    parameter int WARMUP     = WARMUP_DEF,
    parameter int BLOCK_LEN  = BLOCK_LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             enc_valid,
    input  logic [NIB_W-1:0] enc_pcm,
    output logic             slow_en,
    output logic             blk_en,
    output logic             busy,
    output logic             overflow,
    output state_t           state,
    adpcm_stream_ctrl_if.master stream
);
    localparam int DW = $clog2(DECIM);
    localparam int WW = $clog2(WARMUP + 1);
    localparam int NW = $clog2(BLOCK_LEN);

    logic [DW-1:0]     decim_cnt;
    logic [WW-1:0]     warm_cnt;
    logic [NW-1:0]     nib_cnt;
    logic [NIB_W-1:0]  pack_lo;
    logic              take_stop;
    logic              take_nib;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [BYTE_W-1:0] din;
    logic [BYTE_W-1:0] dout;

    // stop beats a same-cycle nibble; nib_cnt is always even in WARMUP, so no flush byte there.
    assign take_stop = stop && (state == S_WARMUP || state == S_RUN);
    assign take_nib  = (state == S_RUN) && enc_valid && !stop;
    assign push      = (take_nib || take_stop) && nib_cnt[0];
    assign din       = take_stop ? {{NIB_W{1'b0}}, pack_lo} : {enc_pcm, pack_lo};
    assign pop       = stream.out_valid && stream.out_ready;

    assign stream.out_valid = !empty;
    assign stream.out_data  = dout;
    assign busy             = (state != S_IDLE);
    assign blk_en           = (state == S_WARMUP) || (state == S_RUN);

    byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            decim_cnt <= '0;
            warm_cnt  <= '0;
            nib_cnt   <= '0;
            pack_lo   <= '0;
            slow_en   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            slow_en <= 1'b0;
            if (state != S_IDLE) begin
                if (decim_cnt == DW'(DECIM - 1)) begin
                    decim_cnt <= '0;
                    slow_en   <= 1'b1;
                end else begin
                    decim_cnt <= decim_cnt + 1'b1;
                end
            end
            if (push && full && !pop) overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_WARMUP;
                        overflow <= 1'b0;
                    end
                end
                S_WARMUP: begin
                    if (stop) begin
                        state    <= S_FLUSH;
                        warm_cnt <= '0;
                    end else if (slow_en) begin
                        if (warm_cnt == WW'(WARMUP - 1)) begin
                            state    <= S_RUN;
                            warm_cnt <= '0;
                        end else begin
                            warm_cnt <= warm_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state   <= S_FLUSH;
                        nib_cnt <= '0;
                        pack_lo <= '0;
                    end else if (enc_valid) begin
                        pack_lo <= nib_cnt[0] ? '0 : enc_pcm;
                        if (nib_cnt == NW'(BLOCK_LEN - 1)) begin
                            state   <= S_FLUSH;
                            nib_cnt <= '0;
                        end else begin
                            nib_cnt <= nib_cnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (empty && !push) begin
                        state     <= S_IDLE;
                        decim_cnt <= '0;
                        warm_cnt  <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adpcm_stream_ctrl.sv
// Directed bench for adpcm_stream_ctrl: stimulus pushes expected bytes, a monitor pops them.
module tb_adpcm_stream_ctrl;
    import adpcm_ctrl_pkg::*;

    localparam int DECIM      = 4;
    localparam int WARMUP     = 2;
    localparam int BLOCK_LEN  = 16;
    localparam int FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             enc_valid = 1'b0;
    logic [NIB_W-1:0] enc_pcm = '0;
    logic             slow_en;
    logic             blk_en;
    logic             busy;
    logic             overflow;
    state_t           state;

    adpcm_stream_ctrl_if sif ();

    adpcm_stream_ctrl #(
        .DECIM(DECIM), .WARMUP(WARMUP), .BLOCK_LEN(BLOCK_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .enc_valid(enc_valid), .enc_pcm(enc_pcm),
        .slow_en(slow_en), .blk_en(blk_en), .busy(busy), .overflow(overflow),
        .state(state), .stream(sif.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    logic [BYTE_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [NIB_W-1:0] n);
        enc_valid = 1'b1;
        enc_pcm   = n;
        tick();
        enc_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (state != S_RUN && n < 100) begin
            tick();
            n++;
        end
        chk("wait_run", 32'(state == S_RUN), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && sif.out_valid && sif.out_ready) begin
                pops++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_byte: got %0h expected none", sif.out_data);
                end else begin
                    logic [BYTE_W-1:0] e;
                    e = exp_q.pop_front();
                    if (sif.out_data !== e) begin
                        miscompares++;
                        $display("FAIL byte: got %0h expected %0h at %0t", sif.out_data, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_mark;
        sif.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_slow_en", 32'(slow_en), 0);
        chk("rst_blk_en", 32'(blk_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_out_valid", 32'(sif.out_valid), 0);
        chk("rst_out_data", 32'(sif.out_data), 0);
        rst = 1'b0;
        tick();

        // warm-up timing and first byte; a second start in WARMUP must not restart counting
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            start = (c == 3);
            tick();
            start = 1'b0;
            chk($sformatf("slow_en_c%0d", c), 32'(slow_en), 32'(c % 4 == 0));
            chk($sformatf("blk_en_c%0d", c), 32'(blk_en), 32'd1);
            if (c == 8) chk("state_c8", 32'(state), 32'(S_WARMUP));
            if (c == 9) chk("state_c9", 32'(state), 32'(S_RUN));
        end
        send_nib(4'h3);
        exp_q.push_back(8'hA3);
        send_nib(4'hA);
        chk("first_valid", 32'(sif.out_valid), 32'd1);
        chk("first_data", 32'(sif.out_data), 32'hA3);
        pulse_stop();
        wait_idle();

        // full block; start with stop from IDLE must still start
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_wins", 32'(state), 32'(S_WARMUP));
        wait_run();
        exp_q.push_back(8'h21); exp_q.push_back(8'h43);
        exp_q.push_back(8'h65); exp_q.push_back(8'h87);
        exp_q.push_back(8'hA9); exp_q.push_back(8'hCB);
        exp_q.push_back(8'hED); exp_q.push_back(8'h0F);
        for (int i = 1; i <= 16; i++) send_nib(NIB_W'(i));
        chk("block_flush", 32'(state), 32'(S_FLUSH));
        wait_idle();

        // odd stop
        pulse_start();
        wait_run();
        exp_q.push_back(8'h65);
        exp_q.push_back(8'h07);
        send_nib(4'h5);
        send_nib(4'h6);
        send_nib(4'h7);
        pulse_stop();
        wait_idle();
        chk("odd_idle", 32'(state), 32'(S_IDLE));

        // backpressure and overflow
        sif.out_ready = 1'b0;
        pulse_start();
        wait_run();
        exp_q.push_back(8'h10); exp_q.push_back(8'h32);
        exp_q.push_back(8'h54); exp_q.push_back(8'h76);
        for (int i = 0; i < 12; i++) send_nib(NIB_W'(i));
        pulse_stop();
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_data", 32'(sif.out_data), 32'h10);
            chk("hold_valid", 32'(sif.out_valid), 32'd1);
        end
        sif.out_ready = 1'b1;
        wait_idle();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        sif.out_ready = 1'b0;
        pulse_start();
        chk("ovf_clear", 32'(overflow), 32'd0);

        // full FIFO with simultaneous push and pop
        wait_run();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        exp_q.push_back(8'h65);
        for (int i = 1; i <= 4; i++) begin
            send_nib(NIB_W'(i));
            send_nib(NIB_W'(i));
        end
        send_nib(4'h5);
        sif.out_ready = 1'b1;
        send_nib(4'h6);
        sif.out_ready = 1'b0;
        chk("pushpop_no_ovf", 32'(overflow), 32'd0);
        pulse_stop();
        pops_mark = pops;
        sif.out_ready = 1'b1;
        wait_idle();
        chk("pushpop_occupancy", 32'(pops - pops_mark), 32'd4);

        // asynchronous reset mid-RUN with a pending nibble
        pulse_start();
        wait_run();
        send_nib(4'h9);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_slow_en", 32'(slow_en), 0);
        chk("arst_blk_en", 32'(blk_en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_overflow", 32'(overflow), 0);
        chk("arst_out_valid", 32'(sif.out_valid), 0);
        chk("arst_out_data", 32'(sif.out_data), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            enc_valid = i[0];
            enc_pcm   = NIB_W'(i);
            tick();
            chk("post_rst_quiet", 32'(sif.out_valid | busy), 32'd0);
        end
        enc_valid = 1'b0;

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
